// File: rtl/gf12_sram_sp_8192x64_hd_if.sv
// rtl/gf12_sram_sp_8192x64_hd_if.sv - single-port SRAM access bus
interface gf12_sram_sp_8192x64_hd_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 13
);
  logic                  CE0;
  logic [ADDR_WIDTH-1:0] A0;
  logic [DATA_WIDTH-1:0] D0;
  logic                  WE0;
  logic [DATA_WIDTH-1:0] WEM0;
  logic [DATA_WIDTH-1:0] Q0;

  modport master (
    output CE0, A0, D0, WE0, WEM0,
    input  Q0
  );

  modport slave (
    input  CE0, A0, D0, WE0, WEM0,
    output Q0
  );
endinterface

// File: rtl/gf12_sram_sp_8192x64_hd.sv
// rtl/gf12_sram_sp_8192x64_hd.sv - GF12 8192x64 single-port SRAM behavioural macro
// One-cycle registered read, per-bit masked write, contents survive reset.
module gf12_sram_sp_8192x64_hd #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 13,
  parameter int WORDS      = 8192
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  gf12_sram_sp_8192x64_hd_if.slave    bus
);

  // Storage starts at zero so never-written words read back as zero.
  logic [DATA_WIDTH-1:0] mem [WORDS] = '{default: '0};

  logic [DATA_WIDTH-1:0] q_q;
  logic [DATA_WIDTH-1:0] q_d;
  logic                  in_range;
  logic                  rd_en;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_word;

  assign in_range = (int'(bus.A0) < WORDS);
  assign rd_en    = RSTN && bus.CE0 && !bus.WE0;
  assign wr_en    = RSTN && bus.CE0 &&  bus.WE0;

  always_comb begin
    q_d = q_q;
    if (rd_en) begin
      if ($isunknown(bus.A0)) begin
        q_d = 'x;
      end else if (in_range) begin
        q_d = mem[bus.A0];
      end else begin
        q_d = '0;
      end
    end
  end

  always_comb begin
    wr_word = '0;
    if (in_range) begin
      wr_word = (mem[bus.A0] & ~bus.WEM0) | (bus.D0 & bus.WEM0);
    end
    // Unknown data or mask poisons the whole target word.
    if ($isunknown({bus.D0, bus.WEM0})) begin
      wr_word = 'x;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en && in_range) begin
      mem[bus.A0] <= wr_word;
    end
  end

  assign bus.Q0 = q_q;

endmodule

// File: tb/tb_gf12_sram_sp_8192x64_hd.sv
// tb/tb_gf12_sram_sp_8192x64_hd.sv - self-checking bench for the 8192x64 SRAM macro
module tb_gf12_sram_sp_8192x64_hd;

  localparam int DW = 64;
  localparam int AW = 13;
  localparam int NW = 8192;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  gf12_sram_sp_8192x64_hd_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) sif ();

  gf12_sram_sp_8192x64_hd #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .WORDS     (NW)
  ) u_dut (
    .CLK (clk),
    .RSTN(rstn),
    .bus (sif.slave)
  );

  logic [DW-1:0] model [NW];
  logic [DW-1:0] exp_q;
  int n_cmp = 0;
  int n_err = 0;

  // Apply one request across one rising edge and advance the reference model.
  task automatic step(input logic r, input logic ce, input logic we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] wem);
    rstn     = r;
    sif.CE0  = ce;
    sif.WE0  = we;
    sif.A0   = a;
    sif.D0   = d;
    sif.WEM0 = wem;
    @(posedge clk);
    if (!r) begin
      exp_q = '0;
    end else if (ce && !we) begin
      exp_q = model[a];
    end else if (ce && we) begin
      model[a] = (model[a] & ~wem) | (d & wem);
    end
    #1;
  endtask

  task automatic test_reset;
    step(1'b0, 1'b1, 1'b0, 13'h0000, '0, '0);
    n_cmp++;
    if (sif.Q0 !== 64'h0) begin
      n_err++;
      $display("FAIL reset_first_edge: got %h want %h", sif.Q0, 64'h0);
    end
    step(1'b0, 1'b1, 1'b1, 13'h0100, 64'hFFFF_0000_FFFF_0000, '1);
    n_cmp++;
    if (sif.Q0 !== 64'h0) begin
      n_err++;
      $display("FAIL reset_second_edge: got %h want %h", sif.Q0, 64'h0);
    end
    step(1'b1, 1'b0, 1'b0, 13'h0000, '0, '0);
    n_cmp++;
    if (sif.Q0 !== 64'h0) begin
      n_err++;
      $display("FAIL reset_release_hold: got %h want %h", sif.Q0, 64'h0);
    end
    step(1'b1, 1'b1, 1'b0, 13'h0100, '0, '0);
    n_cmp++;
    if (sif.Q0 !== 64'h0) begin
      n_err++;
      $display("FAIL reset_blocked_write: got %h want %h", sif.Q0, 64'h0);
    end
  endtask

  task automatic test_full_word;
    step(1'b1, 1'b1, 1'b0, 13'h0005, '0, '0);
    step(1'b1, 1'b1, 1'b1, 13'h0000, 64'h0123_4567_89AB_CDEF, '1);
    n_cmp++;
    if (sif.Q0 !== 64'h0) begin
      n_err++;
      $display("FAIL full_word_no_writethrough: got %h want %h", sif.Q0, 64'h0);
    end
    step(1'b1, 1'b1, 1'b0, 13'h0000, '0, '0);
    n_cmp++;
    if (sif.Q0 !== 64'h0123_4567_89AB_CDEF) begin
      n_err++;
      $display("FAIL full_word_read: got %h want %h", sif.Q0, 64'h0123_4567_89AB_CDEF);
    end
  endtask

  task automatic test_bit_mask;
    step(1'b1, 1'b1, 1'b1, 13'h1FFF, '1, '1);
    step(1'b1, 1'b1, 1'b1, 13'h1FFF, '0, 64'h0000_0000_FFFF_0000);
    step(1'b1, 1'b1, 1'b0, 13'h1FFF, '0, '0);
    n_cmp++;
    if (sif.Q0 !== 64'hFFFF_FFFF_0000_FFFF) begin
      n_err++;
      $display("FAIL bit_mask: got %h want %h", sif.Q0, 64'hFFFF_FFFF_0000_FFFF);
    end
    step(1'b1, 1'b1, 1'b1, 13'h1FFF, 64'h1234, '0);
    step(1'b1, 1'b1, 1'b0, 13'h1FFF, '0, '0);
    n_cmp++;
    if (sif.Q0 !== 64'hFFFF_FFFF_0000_FFFF) begin
      n_err++;
      $display("FAIL zero_mask_write: got %h want %h", sif.Q0, 64'hFFFF_FFFF_0000_FFFF);
    end
  endtask

  task automatic test_back_to_back;
    step(1'b1, 1'b1, 1'b1, 13'h0000, {32{2'b10}}, '1);
    step(1'b1, 1'b1, 1'b1, 13'h1FFF, {32{2'b01}}, '1);
    step(1'b1, 1'b1, 1'b0, 13'h1FFF, '0, '0);
    n_cmp++;
    if (sif.Q0 !== 64'h5555_5555_5555_5555) begin
      n_err++;
      $display("FAIL b2b_first: got %h want %h", sif.Q0, 64'h5555_5555_5555_5555);
    end
    step(1'b1, 1'b1, 1'b0, 13'h0000, '0, '0);
    n_cmp++;
    if (sif.Q0 !== 64'hAAAA_AAAA_AAAA_AAAA) begin
      n_err++;
      $display("FAIL b2b_second: got %h want %h", sif.Q0, 64'hAAAA_AAAA_AAAA_AAAA);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 13'h1FFF, '1, '1);
      n_cmp++;
      if (sif.Q0 !== 64'hAAAA_AAAA_AAAA_AAAA) begin
        n_err++;
        $display("FAIL idle_hold[%0d]: got %h want %h", i, sif.Q0, 64'hAAAA_AAAA_AAAA_AAAA);
      end
    end
  endtask

  task automatic test_reset_retention;
    step(1'b0, 1'b0, 1'b0, 13'h0000, '0, '0);
    n_cmp++;
    if (sif.Q0 !== 64'h0) begin
      n_err++;
      $display("FAIL retention_reset_q: got %h want %h", sif.Q0, 64'h0);
    end
    step(1'b1, 1'b1, 1'b0, 13'h0000, '0, '0);
    n_cmp++;
    if (sif.Q0 !== 64'hAAAA_AAAA_AAAA_AAAA) begin
      n_err++;
      $display("FAIL retention_read: got %h want %h", sif.Q0, 64'hAAAA_AAAA_AAAA_AAAA);
    end
  endtask

  task automatic test_write_read_pipeline;
    step(1'b1, 1'b1, 1'b1, 13'h0ABC, 64'hDEAD_BEEF_CAFE_F00D, '1);
    n_cmp++;
    if (sif.Q0 !== 64'hAAAA_AAAA_AAAA_AAAA) begin
      n_err++;
      $display("FAIL pipe_write_cycle: got %h want %h", sif.Q0, 64'hAAAA_AAAA_AAAA_AAAA);
    end
    step(1'b1, 1'b1, 1'b0, 13'h0ABC, '0, '0);
    n_cmp++;
    if (sif.Q0 !== 64'hDEAD_BEEF_CAFE_F00D) begin
      n_err++;
      $display("FAIL pipe_read: got %h want %h", sif.Q0, 64'hDEAD_BEEF_CAFE_F00D);
    end
    step(1'b1, 1'b1, 1'b0, 13'h0777, '0, '0);
    n_cmp++;
    if (sif.Q0 !== 64'h0) begin
      n_err++;
      $display("FAIL unwritten_read: got %h want %h", sif.Q0, 64'h0);
    end
  endtask

  task automatic test_random;
    logic          r, ce, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d, wem;
    for (int i = 0; i < 10000; i++) begin
      r  = ($urandom_range(0, 99) != 0);
      ce = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1) == 1;
      a  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      d  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       wem = '1;
        1:       wem = '0;
        default: wem = {$urandom, $urandom};
      endcase
      step(r, ce, we, a, d, wem);
      n_cmp++;
      if (sif.Q0 !== exp_q) begin
        n_err++;
        $display("FAIL random[%0d] a=%h: got %h want %h", i, a, sif.Q0, exp_q);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) model[i] = '0;
    exp_q    = '0;
    rstn     = 1'b0;
    sif.CE0  = 1'b0;
    sif.WE0  = 1'b0;
    sif.A0   = '0;
    sif.D0   = '0;
    sif.WEM0 = '0;
    @(negedge clk);
    test_reset;
    test_full_word;
    test_bit_mask;
    test_back_to_back;
    test_reset_retention;
    test_write_read_pipeline;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
